// File: rtl/dispatch_rename_if.sv
// rtl/dispatch_rename_if.sv - dispatch entry type and dispatch-to-station interface
package dispatch_rename_pkg;
    localparam int ROB_DEPTH = 32;
    localparam int TAG_LEN   = $clog2(ROB_DEPTH) - 1;

    typedef logic [TAG_LEN:0] tag_t;

    typedef struct packed {
        logic        valid;
        logic [1:0]  rs_type;
        logic [2:0]  aluop;
        logic        cmp;
        tag_t        rob_num;
        logic        rs1_rdy;
        logic [31:0] rs1_data;
        tag_t        qj;
        logic        rs2_rdy;
        logic [31:0] rs2_data;
        tag_t        qk;
    } dis_ex_t;
endpackage

interface dispatch_rename_if;
    import dispatch_rename_pkg::*;

    dis_ex_t dis_ex_reg;
    logic    add_full;
    logic    mul_full;
    logic    lsq_full;
    logic    bp_full;

    modport master (output dis_ex_reg, input add_full, mul_full, lsq_full, bp_full);
    modport slave  (input dis_ex_reg, output add_full, mul_full, lsq_full, bp_full);
endinterface

// File: rtl/dispatch_rename.sv
// rtl/dispatch_rename.sv - rename/dispatch stage with RAT, ROB tag allocation and CDB snoop
module dispatch_rename
    import dispatch_rename_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        branch_mispredicted,
    input  logic        iq_valid,
    output logic        iq_rd_en,
    input  logic [4:0]  iq_rs1,
    input  logic [4:0]  iq_rs2,
    input  logic [4:0]  iq_rd,
    input  logic        iq_rd_we,
    input  logic [1:0]  iq_rs_type,
    input  logic [2:0]  iq_aluop,
    input  logic        iq_cmp,
    input  logic        iq_use_imm,
    input  logic [31:0] iq_imm,
    output logic [4:0]  rf_rs1_addr,
    output logic [4:0]  rf_rs2_addr,
    input  logic [31:0] rf_rs1_data,
    input  logic [31:0] rf_rs2_data,
    input  logic        rob_full,
    input  tag_t        rob_tail_tag,
    output logic        rob_alloc,
    output tag_t        rob_rs1_tag,
    output tag_t        rob_rs2_tag,
    input  logic        rob_rs1_rdy,
    input  logic        rob_rs2_rdy,
    input  logic [31:0] rob_rs1_data,
    input  logic [31:0] rob_rs2_data,
    input  logic        commit_valid,
    input  logic [4:0]  commit_rd,
    input  tag_t        commit_tag,
    input  logic        alu_rdy,
    input  logic        update_rob,
    input  logic        update_mul,
    input  logic        update_lsq,
    input  logic        update_bp,
    input  tag_t        rob_num_add,
    input  tag_t        cdb_tag1,
    input  tag_t        cdb_tag2,
    input  tag_t        cdb_tag3,
    input  tag_t        cdb_tag4,
    input  logic [31:0] result_add,
    input  logic [31:0] cdb_result1,
    input  logic [31:0] cdb_result2,
    input  logic [31:0] cdb_result3,
    input  logic [31:0] cdb_result4,
    dispatch_rename_if.master dis_if
);
    typedef struct packed {
        logic        hit;
        logic [31:0] data;
    } bc_t;

    typedef struct packed {
        logic        rdy;
        logic [31:0] data;
        tag_t        q;
    } src_t;

    dis_ex_t         dis_q, dis_d;
    logic [31:0]     rat_busy_q, rat_busy_d;
    tag_t [31:0]     rat_tag_q, rat_tag_d;

    logic [4:0]        bc_v;
    tag_t [4:0]        bc_tag;
    logic [4:0][31:0]  bc_data;
    logic              sel_full, out_ready, fire;
    bc_t               bc_rs1, bc_rs2, bc_qj, bc_qk;
    src_t              src1, src2;

    // Index 0 is the highest-priority broadcast (ALU), then ROB, MUL, LSQ, BP.
    assign bc_v    = {update_bp, update_lsq, update_mul, update_rob, alu_rdy};
    assign bc_tag  = {cdb_tag4, cdb_tag3, cdb_tag2, cdb_tag1, rob_num_add};
    assign bc_data = {cdb_result4, cdb_result3, cdb_result2, cdb_result1, result_add};

    function automatic bc_t snoop(input tag_t tag, input logic [4:0] v,
                                  input tag_t [4:0] tags, input logic [4:0][31:0] datas);
        bc_t r;
        r = '0;
        for (int i = 4; i >= 0; i--) begin
            if (v[i] && tags[i] == tag) begin
                r.hit  = 1'b1;
                r.data = datas[i];
            end
        end
        return r;
    endfunction

    function automatic src_t resolve(input logic [4:0] areg, input logic busy, input tag_t tag,
                                     input logic rob_rdy, input logic [31:0] rob_data,
                                     input logic [31:0] rf_data, input bc_t bc);
        src_t r;
        r = '0;
        if (areg == 5'd0) begin
            r.rdy = 1'b1;
        end else if (!busy) begin
            r.rdy  = 1'b1;
            r.data = rf_data;
        end else if (rob_rdy) begin
            r.rdy  = 1'b1;
            r.data = rob_data;
        end else if (bc.hit) begin
            r.rdy  = 1'b1;
            r.data = bc.data;
        end else begin
            r.q = tag;
        end
        return r;
    endfunction

    assign rf_rs1_addr       = iq_rs1;
    assign rf_rs2_addr       = iq_rs2;
    assign rob_rs1_tag       = rat_tag_q[iq_rs1];
    assign rob_rs2_tag       = rat_tag_q[iq_rs2];
    assign dis_if.dis_ex_reg = dis_q;

    // Handshake: select the target station's full flag and decide whether to pop the IQ.
    always_comb begin
        sel_full = 1'b0;
        case (dis_q.rs_type)
            2'b00:   sel_full = dis_if.add_full;
            2'b01:   sel_full = dis_if.mul_full;
            2'b10:   sel_full = dis_if.lsq_full;
            default: sel_full = dis_if.bp_full;
        endcase
        out_ready = !dis_q.valid || !sel_full;
        fire      = iq_valid && !rob_full && out_ready && !branch_mispredicted;
        iq_rd_en  = fire;
        rob_alloc = fire;
    end

    // Source operand resolution for the incoming instruction, using the pre-update RAT.
    always_comb begin
        bc_rs1 = snoop(rat_tag_q[iq_rs1], bc_v, bc_tag, bc_data);
        bc_rs2 = snoop(rat_tag_q[iq_rs2], bc_v, bc_tag, bc_data);
        src1   = resolve(iq_rs1, rat_busy_q[iq_rs1], rat_tag_q[iq_rs1],
                         rob_rs1_rdy, rob_rs1_data, rf_rs1_data, bc_rs1);
        src2   = resolve(iq_rs2, rat_busy_q[iq_rs2], rat_tag_q[iq_rs2],
                         rob_rs2_rdy, rob_rs2_data, rf_rs2_data, bc_rs2);
        if (iq_use_imm) begin
            src2.rdy  = 1'b1;
            src2.data = iq_imm;
            src2.q    = '0;
        end
    end

    // Next dispatch entry: snoop the current entry, then load, clear or hold it.
    always_comb begin
        dis_d = dis_q;
        bc_qj = snoop(dis_q.qj, bc_v, bc_tag, bc_data);
        bc_qk = snoop(dis_q.qk, bc_v, bc_tag, bc_data);
        if (dis_q.valid && !dis_q.rs1_rdy && bc_qj.hit) begin
            dis_d.rs1_rdy  = 1'b1;
            dis_d.rs1_data = bc_qj.data;
            dis_d.qj       = '0;
        end
        if (dis_q.valid && !dis_q.rs2_rdy && bc_qk.hit) begin
            dis_d.rs2_rdy  = 1'b1;
            dis_d.rs2_data = bc_qk.data;
            dis_d.qk       = '0;
        end
        if (branch_mispredicted) begin
            dis_d = '0;
        end else if (fire) begin
            dis_d.valid    = 1'b1;
            dis_d.rs_type  = iq_rs_type;
            dis_d.aluop    = iq_aluop;
            dis_d.cmp      = iq_cmp;
            dis_d.rob_num  = rob_tail_tag;
            dis_d.rs1_rdy  = src1.rdy;
            dis_d.rs1_data = src1.data;
            dis_d.qj       = src1.q;
            dis_d.rs2_rdy  = src2.rdy;
            dis_d.rs2_data = src2.data;
            dis_d.qk       = src2.q;
        end else if (out_ready) begin
            dis_d.valid = 1'b0;
        end
    end

    // RAT update: commit clears a matching mapping; a same-cycle rename overrides it.
    always_comb begin
        rat_busy_d = rat_busy_q;
        rat_tag_d  = rat_tag_q;
        if (branch_mispredicted) begin
            rat_busy_d = '0;
            rat_tag_d  = '0;
        end else begin
            if (commit_valid && rat_tag_q[commit_rd] == commit_tag) begin
                rat_busy_d[commit_rd] = 1'b0;
            end
            if (fire && iq_rd_we && iq_rd != 5'd0) begin
                rat_busy_d[iq_rd] = 1'b1;
                rat_tag_d[iq_rd]  = rob_tail_tag;
            end
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            dis_q      <= '0;
            rat_busy_q <= '0;
            rat_tag_q  <= '0;
        end else begin
            dis_q      <= dis_d;
            rat_busy_q <= rat_busy_d;
            rat_tag_q  <= rat_tag_d;
        end
    end
endmodule

// File: tb/tb_dispatch_rename.sv
// tb/tb_dispatch_rename.sv - directed self-checking bench for dispatch_rename
module tb_dispatch_rename;
    import dispatch_rename_pkg::*;

    logic        clk = 1'b0;
    logic        rst, branch_mispredicted, iq_valid, iq_rd_en;
    logic [4:0]  iq_rs1, iq_rs2, iq_rd, rf_rs1_addr, rf_rs2_addr, commit_rd;
    logic        iq_rd_we, iq_cmp, iq_use_imm;
    logic [1:0]  iq_rs_type;
    logic [2:0]  iq_aluop;
    logic [31:0] iq_imm, rf_rs1_data, rf_rs2_data, rob_rs1_data, rob_rs2_data;
    logic        rob_full, rob_alloc, rob_rs1_rdy, rob_rs2_rdy, commit_valid;
    tag_t        rob_tail_tag, rob_rs1_tag, rob_rs2_tag, commit_tag;
    logic        alu_rdy, update_rob, update_mul, update_lsq, update_bp;
    tag_t        rob_num_add, cdb_tag1, cdb_tag2, cdb_tag3, cdb_tag4;
    logic [31:0] result_add, cdb_result1, cdb_result2, cdb_result3, cdb_result4;

    int checks = 0;
    int errors = 0;

    dispatch_rename_if dif();

    dispatch_rename dut (
        .clk(clk), .rst(rst), .branch_mispredicted(branch_mispredicted),
        .iq_valid(iq_valid), .iq_rd_en(iq_rd_en), .iq_rs1(iq_rs1), .iq_rs2(iq_rs2),
        .iq_rd(iq_rd), .iq_rd_we(iq_rd_we), .iq_rs_type(iq_rs_type), .iq_aluop(iq_aluop),
        .iq_cmp(iq_cmp), .iq_use_imm(iq_use_imm), .iq_imm(iq_imm),
        .rf_rs1_addr(rf_rs1_addr), .rf_rs2_addr(rf_rs2_addr),
        .rf_rs1_data(rf_rs1_data), .rf_rs2_data(rf_rs2_data),
        .rob_full(rob_full), .rob_tail_tag(rob_tail_tag), .rob_alloc(rob_alloc),
        .rob_rs1_tag(rob_rs1_tag), .rob_rs2_tag(rob_rs2_tag),
        .rob_rs1_rdy(rob_rs1_rdy), .rob_rs2_rdy(rob_rs2_rdy),
        .rob_rs1_data(rob_rs1_data), .rob_rs2_data(rob_rs2_data),
        .commit_valid(commit_valid), .commit_rd(commit_rd), .commit_tag(commit_tag),
        .alu_rdy(alu_rdy), .update_rob(update_rob), .update_mul(update_mul),
        .update_lsq(update_lsq), .update_bp(update_bp),
        .rob_num_add(rob_num_add), .cdb_tag1(cdb_tag1), .cdb_tag2(cdb_tag2),
        .cdb_tag3(cdb_tag3), .cdb_tag4(cdb_tag4),
        .result_add(result_add), .cdb_result1(cdb_result1), .cdb_result2(cdb_result2),
        .cdb_result3(cdb_result3), .cdb_result4(cdb_result4),
        .dis_if(dif)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        branch_mispredicted = 0; iq_valid = 0; iq_rs1 = 0; iq_rs2 = 0; iq_rd = 0;
        iq_rd_we = 0; iq_rs_type = 0; iq_aluop = 0; iq_cmp = 0; iq_use_imm = 0; iq_imm = 0;
        rf_rs1_data = 0; rf_rs2_data = 0; rob_full = 0; rob_tail_tag = 0;
        rob_rs1_rdy = 0; rob_rs2_rdy = 0; rob_rs1_data = 0; rob_rs2_data = 0;
        commit_valid = 0; commit_rd = 0; commit_tag = 0;
        alu_rdy = 0; update_rob = 0; update_mul = 0; update_lsq = 0; update_bp = 0;
        rob_num_add = 0; cdb_tag1 = 0; cdb_tag2 = 0; cdb_tag3 = 0; cdb_tag4 = 0;
        result_add = 0; cdb_result1 = 0; cdb_result2 = 0; cdb_result3 = 0; cdb_result4 = 0;
        dif.add_full = 0; dif.mul_full = 0; dif.lsq_full = 0; dif.bp_full = 0;
    endtask

    task automatic iq_set(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                          input logic we, input logic [1:0] typ, input tag_t tail);
        iq_valid = 1; iq_rs1 = rs1; iq_rs2 = rs2; iq_rd = rd; iq_rd_we = we;
        iq_rs_type = typ; rob_tail_tag = tail; iq_use_imm = 0; iq_aluop = 3'd0; iq_cmp = 0;
    endtask

    task automatic test_reset();
        idle();
        rst = 1;
        iq_rs1 = 5'd3;
        tick(); tick();
        checks++; if (dif.dis_ex_reg !== '0) begin errors++; $display("FAIL reset_dis got=%h exp=0", dif.dis_ex_reg); end
        checks++; if (rob_rs1_tag !== 5'd0) begin errors++; $display("FAIL reset_rat_tag got=%0d exp=0", rob_rs1_tag); end
        rst = 0;
        tick();
        checks++; if (dif.dis_ex_reg.valid !== 1'b0) begin errors++; $display("FAIL idle_valid got=%b exp=0", dif.dis_ex_reg.valid); end
    endtask

    task automatic test_basic();
        iq_set(5'd1, 5'd2, 5'd3, 1'b1, 2'b00, 5'd6);
        iq_aluop = 3'd5; iq_cmp = 1;
        rf_rs1_data = 5; rf_rs2_data = 7;
        #1;
        checks++; if (iq_rd_en !== 1'b1 || rob_alloc !== 1'b1) begin errors++; $display("FAIL basic_pop got=%b%b exp=11", iq_rd_en, rob_alloc); end
        checks++; if (rf_rs1_addr !== 5'd1 || rf_rs2_addr !== 5'd2) begin errors++; $display("FAIL basic_rf_addr got=%0d/%0d exp=1/2", rf_rs1_addr, rf_rs2_addr); end
        tick();
        checks++; if (dif.dis_ex_reg.valid !== 1'b1 || dif.dis_ex_reg.rs_type !== 2'b00 || dif.dis_ex_reg.rob_num !== 5'd6) begin errors++; $display("FAIL basic_hdr got=%b/%b/%0d exp=1/00/6", dif.dis_ex_reg.valid, dif.dis_ex_reg.rs_type, dif.dis_ex_reg.rob_num); end
        checks++; if (dif.dis_ex_reg.aluop !== 3'd5 || dif.dis_ex_reg.cmp !== 1'b1) begin errors++; $display("FAIL basic_pass got=%0d/%b exp=5/1", dif.dis_ex_reg.aluop, dif.dis_ex_reg.cmp); end
        checks++; if (dif.dis_ex_reg.rs1_rdy !== 1'b1 || dif.dis_ex_reg.rs1_data !== 32'd5 || dif.dis_ex_reg.rs2_rdy !== 1'b1 || dif.dis_ex_reg.rs2_data !== 32'd7) begin errors++; $display("FAIL basic_src got=%b/%0d %b/%0d exp=1/5 1/7", dif.dis_ex_reg.rs1_rdy, dif.dis_ex_reg.rs1_data, dif.dis_ex_reg.rs2_rdy, dif.dis_ex_reg.rs2_data); end
    endtask

    task automatic test_dependent();
        iq_set(5'd3, 5'd0, 5'd4, 1'b1, 2'b00, 5'd7);
        rf_rs1_data = 32'hdead; rf_rs2_data = 32'hbeef;
        #1;
        checks++; if (rob_rs1_tag !== 5'd6) begin errors++; $display("FAIL dep_rat_tag got=%0d exp=6", rob_rs1_tag); end
        tick();
        checks++; if (dif.dis_ex_reg.rs1_rdy !== 1'b0 || dif.dis_ex_reg.qj !== 5'd6 || dif.dis_ex_reg.rs1_data !== 32'd0) begin errors++; $display("FAIL dep_rs1 got=%b/%0d/%h exp=0/6/0", dif.dis_ex_reg.rs1_rdy, dif.dis_ex_reg.qj, dif.dis_ex_reg.rs1_data); end
        checks++; if (dif.dis_ex_reg.rs2_rdy !== 1'b1 || dif.dis_ex_reg.rs2_data !== 32'd0 || dif.dis_ex_reg.qk !== 5'd0) begin errors++; $display("FAIL dep_x0 got=%b/%h/%0d exp=1/0/0", dif.dis_ex_reg.rs2_rdy, dif.dis_ex_reg.rs2_data, dif.dis_ex_reg.qk); end
    endtask

    task automatic test_bypass();
        iq_set(5'd3, 5'd1, 5'd0, 1'b0, 2'b01, 5'd9);
        rf_rs1_data = 32'hdead; rf_rs2_data = 32'd5;
        update_mul = 1; cdb_tag2 = 5'd6; cdb_result2 = 32'h55;
        tick();
        update_mul = 0;
        checks++; if (dif.dis_ex_reg.rs1_rdy !== 1'b1 || dif.dis_ex_reg.rs1_data !== 32'h55 || dif.dis_ex_reg.qj !== 5'd0) begin errors++; $display("FAIL bypass_mul got=%b/%h/%0d exp=1/55/0", dif.dis_ex_reg.rs1_rdy, dif.dis_ex_reg.rs1_data, dif.dis_ex_reg.qj); end
        checks++; if (dif.dis_ex_reg.rs_type !== 2'b01 || dif.dis_ex_reg.rs2_data !== 32'd5) begin errors++; $display("FAIL bypass_misc got=%b/%0d exp=01/5", dif.dis_ex_reg.rs_type, dif.dis_ex_reg.rs2_data); end
        iq_set(5'd3, 5'd4, 5'd0, 1'b0, 2'b11, 5'd5);
        iq_use_imm = 1; iq_imm = 32'h1234;
        alu_rdy = 1; rob_num_add = 5'd6; result_add = 32'ha;
        update_bp = 1; cdb_tag4 = 5'd6; cdb_result4 = 32'hb;
        tick();
        alu_rdy = 0; update_bp = 0;
        checks++; if (dif.dis_ex_reg.rs1_rdy !== 1'b1 || dif.dis_ex_reg.rs1_data !== 32'ha) begin errors++; $display("FAIL bypass_prio got=%b/%h exp=1/a", dif.dis_ex_reg.rs1_rdy, dif.dis_ex_reg.rs1_data); end
        checks++; if (dif.dis_ex_reg.rs2_rdy !== 1'b1 || dif.dis_ex_reg.rs2_data !== 32'h1234 || dif.dis_ex_reg.qk !== 5'd0) begin errors++; $display("FAIL imm got=%b/%h/%0d exp=1/1234/0", dif.dis_ex_reg.rs2_rdy, dif.dis_ex_reg.rs2_data, dif.dis_ex_reg.qk); end
        iq_set(5'd4, 5'd0, 5'd0, 1'b0, 2'b00, 5'd5);
        rob_rs1_rdy = 1; rob_rs1_data = 32'hbeef;
        tick();
        rob_rs1_rdy = 0;
        checks++; if (dif.dis_ex_reg.rs1_rdy !== 1'b1 || dif.dis_ex_reg.rs1_data !== 32'hbeef) begin errors++; $display("FAIL rob_rdy got=%b/%h exp=1/beef", dif.dis_ex_reg.rs1_rdy, dif.dis_ex_reg.rs1_data); end
    endtask

    task automatic test_hold();
        iq_set(5'd3, 5'd0, 5'd6, 1'b1, 2'b00, 5'd10);
        iq_use_imm = 1; iq_imm = 32'h100;
        tick();
        checks++; if (dif.dis_ex_reg.rs1_rdy !== 1'b0 || dif.dis_ex_reg.qj !== 5'd6 || dif.dis_ex_reg.rs2_data !== 32'h100) begin errors++; $display("FAIL hold_load got=%b/%0d/%h exp=0/6/100", dif.dis_ex_reg.rs1_rdy, dif.dis_ex_reg.qj, dif.dis_ex_reg.rs2_data); end
        dif.add_full = 1;
        iq_set(5'd1, 5'd2, 5'd7, 1'b1, 2'b10, 5'd11);
        #1;
        checks++; if (iq_rd_en !== 1'b0 || rob_alloc !== 1'b0) begin errors++; $display("FAIL hold_nopop1 got=%b%b exp=00", iq_rd_en, rob_alloc); end
        tick();
        checks++; if (dif.dis_ex_reg.valid !== 1'b1 || dif.dis_ex_reg.rob_num !== 5'd10 || dif.dis_ex_reg.rs1_rdy !== 1'b0) begin errors++; $display("FAIL hold_c1 got=%b/%0d/%b exp=1/10/0", dif.dis_ex_reg.valid, dif.dis_ex_reg.rob_num, dif.dis_ex_reg.rs1_rdy); end
        update_lsq = 1; cdb_tag3 = 5'd6; cdb_result3 = 32'd9;
        tick();
        update_lsq = 0;
        checks++; if (dif.dis_ex_reg.rs1_rdy !== 1'b1 || dif.dis_ex_reg.rs1_data !== 32'd9 || dif.dis_ex_reg.qj !== 5'd0 || dif.dis_ex_reg.rob_num !== 5'd10) begin errors++; $display("FAIL hold_snoop got=%b/%0d/%0d/%0d exp=1/9/0/10", dif.dis_ex_reg.rs1_rdy, dif.dis_ex_reg.rs1_data, dif.dis_ex_reg.qj, dif.dis_ex_reg.rob_num); end
        checks++; if (iq_rd_en !== 1'b0) begin errors++; $display("FAIL hold_nopop2 got=%b exp=0", iq_rd_en); end
        tick();
        checks++; if (dif.dis_ex_reg.rob_num !== 5'd10 || dif.dis_ex_reg.valid !== 1'b1) begin errors++; $display("FAIL hold_c3 got=%0d/%b exp=10/1", dif.dis_ex_reg.rob_num, dif.dis_ex_reg.valid); end
        dif.add_full = 0;
        #1;
        checks++; if (iq_rd_en !== 1'b1) begin errors++; $display("FAIL hold_release got=%b exp=1", iq_rd_en); end
        tick();
        checks++; if (dif.dis_ex_reg.rob_num !== 5'd11 || dif.dis_ex_reg.rs_type !== 2'b10) begin errors++; $display("FAIL hold_next got=%0d/%b exp=11/10", dif.dis_ex_reg.rob_num, dif.dis_ex_reg.rs_type); end
        iq_valid = 0;
        tick();
        checks++; if (dif.dis_ex_reg.valid !== 1'b0) begin errors++; $display("FAIL hold_drain got=%b exp=0", dif.dis_ex_reg.valid); end
    endtask

    task automatic test_commit();
        iq_set(5'd1, 5'd2, 5'd3, 1'b1, 2'b00, 5'd8);
        commit_valid = 1; commit_rd = 5'd3; commit_tag = 5'd6;
        tick();
        commit_valid = 0;
        iq_set(5'd3, 5'd0, 5'd0, 1'b0, 2'b00, 5'd14);
        #1;
        checks++; if (rob_rs1_tag !== 5'd8) begin errors++; $display("FAIL commit_rename_tag got=%0d exp=8", rob_rs1_tag); end
        tick();
        checks++; if (dif.dis_ex_reg.rs1_rdy !== 1'b0 || dif.dis_ex_reg.qj !== 5'd8) begin errors++; $display("FAIL commit_rename_busy got=%b/%0d exp=0/8", dif.dis_ex_reg.rs1_rdy, dif.dis_ex_reg.qj); end
        iq_valid = 0;
        commit_valid = 1; commit_rd = 5'd3; commit_tag = 5'd6;
        tick();
        commit_valid = 0;
        iq_set(5'd3, 5'd0, 5'd0, 1'b0, 2'b00, 5'd15);
        tick();
        checks++; if (dif.dis_ex_reg.rs1_rdy !== 1'b0 || dif.dis_ex_reg.qj !== 5'd8) begin errors++; $display("FAIL commit_stale got=%b/%0d exp=0/8", dif.dis_ex_reg.rs1_rdy, dif.dis_ex_reg.qj); end
        iq_valid = 0;
        commit_valid = 1; commit_rd = 5'd3; commit_tag = 5'd8;
        tick();
        commit_valid = 0;
        iq_set(5'd3, 5'd0, 5'd0, 1'b0, 2'b00, 5'd15);
        rf_rs1_data = 32'h77;
        tick();
        checks++; if (dif.dis_ex_reg.rs1_rdy !== 1'b1 || dif.dis_ex_reg.rs1_data !== 32'h77 || dif.dis_ex_reg.qj !== 5'd0) begin errors++; $display("FAIL commit_clear got=%b/%h/%0d exp=1/77/0", dif.dis_ex_reg.rs1_rdy, dif.dis_ex_reg.rs1_data, dif.dis_ex_reg.qj); end
    endtask

    task automatic test_rob_full();
        iq_set(5'd1, 5'd2, 5'd5, 1'b1, 2'b01, 5'd16);
        tick();
        checks++; if (dif.dis_ex_reg.valid !== 1'b1 || dif.dis_ex_reg.rob_num !== 5'd16) begin errors++; $display("FAIL robfull_pre got=%b/%0d exp=1/16", dif.dis_ex_reg.valid, dif.dis_ex_reg.rob_num); end
        rob_full = 1;
        rob_tail_tag = 5'd17;
        #1;
        checks++; if (iq_rd_en !== 1'b0 || rob_alloc !== 1'b0) begin errors++; $display("FAIL robfull_nopop got=%b%b exp=00", iq_rd_en, rob_alloc); end
        tick();
        checks++; if (dif.dis_ex_reg.valid !== 1'b0) begin errors++; $display("FAIL robfull_drain got=%b exp=0", dif.dis_ex_reg.valid); end
        rob_full = 0;
        iq_valid = 0;
    endtask

    task automatic test_mispredict();
        iq_set(5'd1, 5'd2, 5'd3, 1'b1, 2'b00, 5'd17);
        tick();
        iq_set(5'd1, 5'd2, 5'd9, 1'b1, 2'b10, 5'd18);
        tick();
        checks++; if (dif.dis_ex_reg.valid !== 1'b1) begin errors++; $display("FAIL flush_pre got=%b exp=1", dif.dis_ex_reg.valid); end
        branch_mispredicted = 1;
        #1;
        checks++; if (iq_rd_en !== 1'b0 || rob_alloc !== 1'b0) begin errors++; $display("FAIL flush_nopop got=%b%b exp=00", iq_rd_en, rob_alloc); end
        tick();
        branch_mispredicted = 0;
        checks++; if (dif.dis_ex_reg !== '0) begin errors++; $display("FAIL flush_dis got=%h exp=0", dif.dis_ex_reg); end
        iq_set(5'd3, 5'd9, 5'd0, 1'b0, 2'b00, 5'd19);
        rf_rs1_data = 32'h33; rf_rs2_data = 32'h99;
        #1;
        checks++; if (rob_rs1_tag !== 5'd0 || rob_rs2_tag !== 5'd0) begin errors++; $display("FAIL flush_rat_tag got=%0d/%0d exp=0/0", rob_rs1_tag, rob_rs2_tag); end
        tick();
        checks++; if (dif.dis_ex_reg.rs1_rdy !== 1'b1 || dif.dis_ex_reg.rs1_data !== 32'h33 || dif.dis_ex_reg.rs2_rdy !== 1'b1 || dif.dis_ex_reg.rs2_data !== 32'h99) begin errors++; $display("FAIL flush_rf got=%b/%h %b/%h exp=1/33 1/99", dif.dis_ex_reg.rs1_rdy, dif.dis_ex_reg.rs1_data, dif.dis_ex_reg.rs2_rdy, dif.dis_ex_reg.rs2_data); end
        iq_valid = 0;
        tick();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_dependent();
        test_bypass();
        test_hold();
        test_commit();
        test_rob_full();
        test_mispredict();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
